// File: rtl/nzet_pkg.sv
// Shared types and helpers for the nonzero-element stream extractor.
// FSM state enum, popcount and width helpers.
package nzet_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam int MAXN = 64;

  function automatic int unsigned popcnt(
    input logic [MAXN-1:0] m
  );
    int unsigned c;
    c = 0;
    for (int i = 0; i < MAXN; i++)
      if (m[i]) c++;
    return c;
  endfunction

  // bits needed to hold a count 0..n
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/nzet_stream_lsb_pick.sv
// Lowest-set-bit picker: one-hot of the lowest set bit of mask, its index,
// and the mask with that bit cleared. Ports: mask in; onehot, idx, rest out.
module nzet_lsb_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         mask,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx,
  output logic [N-1:0]         rest
);

  localparam int IW = $clog2(N);

  // m & -m isolates the lowest set bit
  assign onehot = mask & (~mask + N'(1));
  assign rest   = mask ^ onehot;

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++)
      if (onehot[i]) idx = IW'(i);
  end

endmodule

// File: rtl/nzet_stream.sv
// Streaming nonzero-element extractor: emits set lanes of a masked N-lane
// vector, up to K per beat, ascending index, valid/ready on both sides.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_mask/in_data;
// out_valid/out_ready/out_data/out_idx/out_cnt/out_last.
// Build option: NZET_SKIP_EMPTY_EN drops all-zero masks without a beat.
module nzet_stream
  import nzet_pkg::*;
#(
  parameter int N = 4,
  parameter int K = 2,
  parameter int W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_mask,
  input  logic [N*W-1:0]             in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [K*W-1:0]             out_data,
  output logic [K*$clog2(N)-1:0]     out_idx,
  output logic [$clog2(K+1)-1:0]     out_cnt,
  output logic                       out_last
);

  localparam int IDXW = $clog2(N);
  localparam int CW   = cnt_w(N);
  localparam int OCW  = $clog2(K + 1);

  state_t state, state_n;

  logic [N*W-1:0] data_q;
  logic [N-1:0]   rem;

  logic [N-1:0]    m  [K+1];
  logic [N-1:0]    oh [K];
  logic [IDXW-1:0] ix [K];

  logic          busy;
  logic [CW-1:0] pc;
  logic [CW-1:0] cnt;
  logic          last;
  logic          acc_in;
  logic          acc_last;
  logic          skip;

  assign busy = (state == BUSY);
  assign m[0] = rem;

  // K chained pickers; each strips the previous pick
  for (genvar j = 0; j < K; j++) begin : g_slot
    logic [W-1:0] sd;

    nzet_lsb_pick #(.N(N)) u_pick (
      .mask   (m[j]),
      .onehot (oh[j]),
      .idx    (ix[j]),
      .rest   (m[j+1])
    );

    always_comb begin
      sd = '0;
      for (int i = 0; i < N; i++)
        if (oh[j][i]) sd = data_q[i*W +: W];
    end

    assign out_data[j*W +: W] =
      busy ? sd : '0;
    assign out_idx[j*IDXW +: IDXW] =
      busy ? ix[j] : '0;
  end

  assign pc   = CW'(popcnt(MAXN'(rem)));
  assign cnt  = (pc > CW'(K)) ? CW'(K) : pc;
  assign last = (pc <= CW'(K));

`ifdef NZET_SKIP_EMPTY_EN
  assign skip = (in_mask == '0);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    out_valid = busy;
    out_cnt   = busy ? OCW'(cnt) : '0;
    out_last  = busy & last;
    acc_last  = busy & out_ready & last;
    in_ready  = !busy || acc_last;
    acc_in    = in_valid & in_ready;
    unique case (state)
      IDLE: begin
        if (acc_in && !skip)
          state_n = BUSY;
      end
      BUSY: begin
        if (acc_in && !skip)
          state_n = BUSY;
        else if (acc_last)
          state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem    <= '0;
      data_q <= '0;
    end else if (acc_in) begin
      rem    <= in_mask;
      data_q <= in_data;
    end else if (busy && out_ready) begin
      rem    <= m[K];
    end
  end

endmodule

// File: tb/tb_nzet_stream.sv
// Self-checking bench for nzet_stream: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_nzet_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, out_last;
  logic [3:0]  in_mask;
  logic [63:0] in_data;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic [1:0]  out_cnt;

  logic         in8_valid, in8_ready, out8_valid, out8_ready, out8_last;
  logic [7:0]   in8_mask;
  logic [127:0] in8_data;
  logic [47:0]  out8_data;
  logic [8:0]   out8_idx;
  logic [1:0]   out8_cnt;

  nzet_stream #(.N(4), .K(2), .W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mask(in_mask), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx),
    .out_cnt(out_cnt), .out_last(out_last)
  );

  nzet_stream #(.N(8), .K(3), .W(16)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in8_valid), .in_ready(in8_ready),
    .in_mask(in8_mask), .in_data(in8_data),
    .out_valid(out8_valid), .out_ready(out8_ready),
    .out_data(out8_data), .out_idx(out8_idx),
    .out_cnt(out8_cnt), .out_last(out8_last)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] data;
    logic [1:0]  cnt;
    logic        last;
  } beat_t;

  typedef struct {
    logic [3:0] mask;
    int         nb;
    beat_t      b [2];
  } vec_t;

  localparam logic [63:0] DATA =
    {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};

  beat_t q [$];
  beat_t held;
  logic  stall = 1'b0;
  logic  in_acc = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic beat_t cur();
    return {out_idx, out_data, out_cnt, out_last};
  endfunction

  // Reference: list set lanes ascending, cut into groups of two.
  task automatic model_push(input logic [3:0] mask,
                            input logic [63:0] data);
    int lanes [$];
    beat_t b;
    for (int i = 0; i < 4; i++)
      if (mask[i]) lanes.push_back(i);
    if (lanes.size() == 0) begin
`ifndef NZET_SKIP_EMPTY_EN
      b = '0;
      b.last = 1'b1;
      q.push_back(b);
`endif
    end
    while (lanes.size() > 0) begin
      b = '0;
      for (int s = 0; s < 2; s++) begin
        if (lanes.size() > 0) begin
          int l;
          l = lanes.pop_front();
          b.idx[s*2 +: 2]   = 2'(l);
          b.data[s*16 +: 16] = data[l*16 +: 16];
          b.cnt = b.cnt + 2'd1;
        end
      end
      b.last = (lanes.size() == 0);
      q.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stall  = 1'b0;
      in_acc = 1'b0;
    end else begin
      if (stall)
        chk("hold", {out_valid, cur()}, {1'b1, held});
      if (out_valid && out_ready) begin
        if (q.size() == 0)
          chk("spurious_beat", 64'(out_valid), 64'd0);
        else
          chk("beat", cur(), q.pop_front());
      end
      stall  = out_valid && !out_ready;
      held   = cur();
      in_acc = in_valid && in_ready;
      if (in_acc) model_push(in_mask, in_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] mask);
    int n;
    in_valid = 1'b1;
    in_mask  = mask;
    in_data  = DATA;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_beat(output beat_t b);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("beat_timeout", 64'd0, 64'd1);
    b = cur();
  endtask

  vec_t tv [8];
  beat_t bt;
  logic [8:0] e8_idx [3];
  logic [1:0] e8_cnt [3];

  initial begin
    tv[0] = '{4'b1011, 2, '{{4'b0100, 32'hBBBBAAAA, 2'd2, 1'b0},
                           {4'b0011, 32'h0000DDDD, 2'd1, 1'b1}}};
    tv[1] = '{4'b0001, 1, '{{4'b0000, 32'h0000AAAA, 2'd1, 1'b1},
                           '0}};
    tv[2] = '{4'b1000, 1, '{{4'b0011, 32'h0000DDDD, 2'd1, 1'b1},
                           '0}};
    tv[3] = '{4'b0110, 1, '{{4'b1001, 32'hCCCCBBBB, 2'd2, 1'b1},
                           '0}};
    tv[4] = '{4'b1111, 2, '{{4'b0100, 32'hBBBBAAAA, 2'd2, 1'b0},
                           {4'b1110, 32'hDDDDCCCC, 2'd2, 1'b1}}};
    tv[5] = '{4'b1100, 1, '{{4'b1110, 32'hDDDDCCCC, 2'd2, 1'b1},
                           '0}};
`ifdef NZET_SKIP_EMPTY_EN
    tv[6] = '{4'b0000, 0, '{'0, '0}};
`else
    tv[6] = '{4'b0000, 1, '{{4'b0000, 32'h0, 2'd0, 1'b1}, '0}};
`endif
    tv[7] = '{4'b0111, 2, '{{4'b0100, 32'hBBBBAAAA, 2'd2, 1'b0},
                           {4'b0010, 32'h0000CCCC, 2'd1, 1'b1}}};

    rst = 1'b1;
    in_valid = 1'b0; in_mask = '0; in_data = '0; out_ready = 1'b0;
    in8_valid = 1'b0; in8_mask = '0; in8_data = '0; out8_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_last",  64'(out_last),  64'd0);
    chk("rst_cnt",   64'(out_cnt),   64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    chk("rst_idx",   64'(out_idx),   64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // directed table
    out_ready = 1'b1;
    for (int e = 0; e < 8; e++) begin
      send(tv[e].mask);
      if (tv[e].nb == 0) begin
        @(negedge clk);
        chk($sformatf("tbl%0d_nobeat", e), 64'(out_valid), 64'd0);
        chk($sformatf("tbl%0d_ready", e), 64'(in_ready), 64'd1);
        tick();
      end else begin
        for (int b = 0; b < tv[e].nb; b++) begin
          wait_beat(bt);
          chk($sformatf("tbl%0d_b%0d", e, b), bt, tv[e].b[b]);
        end
        tick();
      end
    end

    // back-to-back vectors, no bubble
    in_valid = 1'b1; in_mask = 4'b0110; in_data = DATA;
    @(negedge clk);
    chk("b2b_ready0", 64'(in_ready), 64'd1);
    tick();
    in_mask = 4'b1001;
    @(negedge clk);
    chk("b2b_beat1", cur(), {4'b1001, 32'hCCCCBBBB, 2'd2, 1'b1});
    chk("b2b_ready1", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_beat2", cur(), {4'b1100, 32'hDDDDAAAA, 2'd2, 1'b1});
    tick();

    // backpressure on first beat
    out_ready = 1'b0;
    send(4'b1111);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_hold", {out_valid, cur()},
          {1'b1, 4'b0100, 32'hBBBBAAAA, 2'd2, 1'b0});
    end
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", cur(), {4'b0100, 32'hBBBBAAAA, 2'd2, 1'b0});
    @(negedge clk);
    chk("bp_beat2", cur(), {4'b1110, 32'hDDDDCCCC, 2'd2, 1'b1});
    tick();

    // reset mid-vector
    out_ready = 1'b0;
    send(4'b1111);
    @(negedge clk);
    chk("rb_valid", 64'(out_valid), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rb_flush_valid", 64'(out_valid), 64'd0);
    chk("rb_flush_ready", 64'(in_ready), 64'd1);
    tick();
    out_ready = 1'b1;
    send(4'b0001);
    wait_beat(bt);
    chk("rb_fresh", bt, {4'b0000, 32'h0000AAAA, 2'd1, 1'b1});
    tick();

    // N=8, K=3 full mask
    for (int i = 0; i < 8; i++) in8_data[i*16 +: 16] = 16'(16'h0100 + i);
    e8_idx[0] = {3'd2, 3'd1, 3'd0};
    e8_idx[1] = {3'd5, 3'd4, 3'd3};
    e8_idx[2] = {3'd0, 3'd7, 3'd6};
    e8_cnt[0] = 2'd3; e8_cnt[1] = 2'd3; e8_cnt[2] = 2'd2;
    out8_ready = 1'b1;
    in8_valid = 1'b1; in8_mask = 8'hFF;
    @(negedge clk);
    chk("n8_ready", 64'(in8_ready), 64'd1);
    tick();
    in8_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      chk($sformatf("n8_b%0d", b),
          {out8_valid, out8_idx, out8_cnt, out8_last},
          {1'b1, e8_idx[b], e8_cnt[b], b == 2});
    end
    chk("n8_b2_data", 64'(out8_data), 64'h0000_0107_0106);
    @(negedge clk);
    chk("n8_done", 64'(out8_valid), 64'd0);
    tick();

    // randomized traffic against the model
    in_valid = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!in_valid || in_acc) begin
        in_valid = ($urandom_range(0, 99) < 60);
        in_mask  = ($urandom_range(0, 5) == 0) ? 4'b0 : 4'($urandom);
        in_data  = {$urandom, $urandom};
      end
      out_ready = ($urandom_range(0, 99) < 70);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    chk("drain_q", 64'(q.size()), 64'd0);
    chk("drain_valid", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
